// File: rtl/sincronizador_2ff.sv
// sincronizador_2ff: two-flop synchronizer bringing an asynchronous input into the clk domain.
module sincronizador_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) {q, meta_q} <= 2'b00;
      else     {q, meta_q} <= {meta_q, d};
endmodule

// File: rtl/filtro_rebote.sv
// filtro_rebote: contact debouncer; output follows the synchronized input only after N stable cycles.
module filtro_rebote #(
   parameter int DURACION_MS = 50,
   parameter int CLK_KHZ     = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic pulso_real,
   output logic pulso_ideal
);
   localparam int N = DURACION_MS * CLK_KHZ;
   localparam int W = $clog2(N + 1);
   logic         sync;
   logic [W-1:0] cnt_q, cnt_d;
   logic         ideal_q, ideal_d;
   logic         differs, done;
   sincronizador_2ff u_sync (.clk(clk), .rst(rst), .d(pulso_real), .q(sync));
   // Any cycle where sync agrees with the output restarts the window, so bounces never accumulate.
   always_comb begin
      differs = sync != ideal_q;
      done    = differs && (cnt_q == W'(N - 1));
      cnt_d   = (!differs || done) ? '0 : cnt_q + W'(1);
      ideal_d = done ? sync : ideal_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt_q   <= '0;
         ideal_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         ideal_q <= ideal_d;
      end
   assign pulso_ideal = ideal_q;
endmodule

// File: tb/tb_filtro_rebote.sv
// tb_filtro_rebote: table-driven check of filtro_rebote with N=3 (DURACION_MS=3, CLK_KHZ=1).
module tb_filtro_rebote;
   typedef struct {
      logic       rst;
      logic       din;
      logic       glitch;
      logic       ideal;
      logic [1:0] cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pulso_real = 1'b0;
   logic pulso_ideal;
   int   checks = 0;
   int   errors = 0;
   vec_t tv1[$];
   vec_t tv2[$];

   filtro_rebote #(.DURACION_MS(3), .CLK_KHZ(1)) dut (
      .clk(clk), .rst(rst), .pulso_real(pulso_real), .pulso_ideal(pulso_ideal)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(inout vec_t q[$], input logic r, input logic d, input logic g,
                      input logic i, input logic [1:0] c);
      vec_t v;
      v.rst = r; v.din = d; v.glitch = g; v.ideal = i; v.cnt = c;
      q.push_back(v);
   endtask

   task automatic run_vec(input vec_t v, input string tag, input int idx);
      @(negedge clk);
      rst = v.rst;
      if (v.glitch) begin
         pulso_real = 1'b0;
         #2 pulso_real = 1'b1;
         #5 pulso_real = 1'b0;
      end else pulso_real = v.din;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d].ideal", tag, idx), int'(pulso_ideal), int'(v.ideal));
      check($sformatf("%s[%0d].cnt", tag, idx), int'(dut.cnt_q), int'(v.cnt));
   endtask

   initial begin
      // reset held with input high: everything stays 0
      repeat (3) add(tv1, 1, 1, 0, 0, 0);
      repeat (2) add(tv1, 0, 0, 0, 0, 0);
      // clean rise: output rises on the 5th edge
      add(tv1, 0, 1, 0, 0, 0); add(tv1, 0, 1, 0, 0, 0); add(tv1, 0, 1, 0, 0, 1);
      add(tv1, 0, 1, 0, 0, 2); add(tv1, 0, 1, 0, 1, 0);
      repeat (5) add(tv1, 0, 1, 0, 1, 0);
      // clean fall with bounce: low 2, high 1, then low
      add(tv1, 0, 0, 0, 1, 0); add(tv1, 0, 0, 0, 1, 0); add(tv1, 0, 1, 0, 1, 1);
      add(tv1, 0, 0, 0, 1, 2); add(tv1, 0, 0, 0, 1, 0); add(tv1, 0, 0, 0, 1, 1);
      add(tv1, 0, 0, 0, 1, 2); add(tv1, 0, 0, 0, 0, 0); add(tv1, 0, 0, 0, 0, 0);
      // bounce rejection: 1-high, 1-low, 2-high, 1-low, then settle high
      add(tv1, 0, 1, 0, 0, 0); add(tv1, 0, 0, 0, 0, 0); add(tv1, 0, 1, 0, 0, 1);
      add(tv1, 0, 1, 0, 0, 0); add(tv1, 0, 0, 0, 0, 1); add(tv1, 0, 1, 0, 0, 2);
      add(tv1, 0, 1, 0, 0, 0); add(tv1, 0, 1, 0, 0, 1); add(tv1, 0, 1, 0, 0, 2);
      add(tv1, 0, 1, 0, 1, 0); add(tv1, 0, 1, 0, 1, 0);
      // reset mid-count during a rise, then restart with input held high
      repeat (2) add(tv2, 0, 0, 0, 0, 0);
      add(tv2, 0, 1, 0, 0, 0); add(tv2, 0, 1, 0, 0, 0); add(tv2, 0, 1, 0, 0, 1);
      add(tv2, 0, 1, 0, 0, 2); add(tv2, 1, 1, 0, 0, 0);
      add(tv2, 0, 1, 0, 0, 0); add(tv2, 0, 1, 0, 0, 0); add(tv2, 0, 1, 0, 0, 1);
      add(tv2, 0, 1, 0, 0, 2); add(tv2, 0, 1, 0, 1, 0);

      foreach (tv1[i]) run_vec(tv1[i], "seq", i);

      // asynchronous reset: output high, rst asserted between edges clears it at once
      @(negedge clk);
      check("pre_async.ideal", int'(pulso_ideal), 1);
      rst = 1'b1;
      #1;
      check("async_rst.ideal", int'(pulso_ideal), 0);
      check("async_rst.cnt", int'(dut.cnt_q), 0);
      @(negedge clk);
      pulso_real = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // 5 ns pulse between edges is never sampled
      begin
         vec_t g;
         g.rst = 0; g.din = 0; g.glitch = 1; g.ideal = 0; g.cnt = 0;
         run_vec(g, "glitch", 0);
         g.glitch = 0;
         for (int i = 1; i < 8; i++) run_vec(g, "glitch", i);
      end

      foreach (tv2[i]) run_vec(tv2[i], "midrst", i);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
